// File: rtl/psg_bus_pkg.sv
// Shared types for the PSG bus sequencer: bus-mode encodings, FSM states and
// the command word that flows through the player FIFO.
package psg_bus_pkg;

  // {BDIR, BC} encodings
  localparam logic [1:0] BusIdle  = 2'b00;
  localparam logic [1:0] BusRead  = 2'b01;
  localparam logic [1:0] BusWrite = 2'b10;
  localparam logic [1:0] BusAddr  = 2'b11;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StGap  = 3'd2,
    StXfer = 3'd3,
    StDone = 3'd4
  } psg_state_e;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } psg_cmd_t;

endpackage

// File: rtl/psg_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count; full/empty derive
// from the count, so a push into an empty FIFO is visible one cycle later.
module psg_cmd_fifo
  import psg_bus_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  input  logic     push_i,
  input  psg_cmd_t wdata_i,
  input  logic     pop_i,
  output psg_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  psg_cmd_t        mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/psg_bus_sequencer.sv
// Arbitrates CPU accesses and buffered player writes onto the PSG BDIR/BC bus,
// skipping the address-latch phase when the PSG already holds the register.
module psg_bus_sequencer
  import psg_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned ADDR_CACHE  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CPU_REQ,
  input  logic       CPU_WE,
  input  logic [3:0] CPU_ADDR,
  input  logic [7:0] CPU_WDATA,
  output logic       CPU_ACK,
  output logic [7:0] CPU_RDATA,
  input  logic       PL_VALID,
  output logic       PL_READY,
  input  logic [3:0] PL_ADDR,
  input  logic [7:0] PL_DATA,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic [7:0] PSG_DI,
  input  logic [7:0] PSG_DO,
  output logic       BUSY
);

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  psg_state_e state_q, state_d;
  psg_cmd_t   cmd_q, cmd_d, grant_cmd, fifo_cmd, pl_cmd;
  logic       cmd_cpu_q, cmd_cpu_d;
  logic       last_cpu_q, last_cpu_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] cache_addr_q, cache_addr_d;
  logic       cache_valid_q, cache_valid_d;
  logic [7:0] rdata_q, rdata_d;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic       grant_cpu, grant_pl, cache_hit;
  logic [1:0] bus;

  assign pl_cmd = '{we: 1'b1, addr: PL_ADDR, data: PL_DATA};

  psg_cmd_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .RESET  (RESET),
    .push_i (PL_VALID),
    .wdata_i(pl_cmd),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_cmd),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Round-robin: the CPU loses a tie only if it was granted last.
  assign grant_cpu = CPU_REQ && (fifo_empty || !last_cpu_q);
  assign grant_pl  = !fifo_empty && !grant_cpu;

  always_comb begin
    grant_cmd    = fifo_cmd;
    grant_cmd.we = 1'b1;
    if (grant_cpu) grant_cmd = '{we: CPU_WE, addr: CPU_ADDR, data: CPU_WDATA};
  end

  assign cache_hit = (ADDR_CACHE != 0) && cache_valid_q && (cache_addr_q == grant_cmd.addr);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cmd_cpu_d     = cmd_cpu_q;
    last_cpu_d    = last_cpu_q;
    hold_d        = hold_q;
    cache_addr_d  = cache_addr_q;
    cache_valid_d = cache_valid_q;
    rdata_d       = rdata_q;
    fifo_pop      = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_cpu || grant_pl) begin
          cmd_d      = grant_cmd;
          cmd_cpu_d  = grant_cpu;
          last_cpu_d = grant_cpu;
          fifo_pop   = grant_pl;
          hold_d     = HoldLast;
          state_d    = cache_hit ? StXfer : StAddr;
        end
      end
      StAddr: begin
        if (hold_q == '0) begin
          state_d       = StGap;
          cache_addr_d  = cmd_q.addr;
          cache_valid_d = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      StGap: begin
        state_d = StXfer;
        hold_d  = HoldLast;
      end
      StXfer: begin
        if (hold_q == '0) begin
          state_d = StDone;
          if (!cmd_q.we) rdata_d = PSG_DO;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      cmd_cpu_q     <= 1'b0;
      last_cpu_q    <= 1'b0;
      hold_q        <= '0;
      cache_addr_q  <= '0;
      cache_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cmd_cpu_q     <= cmd_cpu_d;
      last_cpu_q    <= last_cpu_d;
      hold_q        <= hold_d;
      cache_addr_q  <= cache_addr_d;
      cache_valid_q <= cache_valid_d;
      rdata_q       <= rdata_d;
    end
  end

  always_comb begin
    bus    = BusIdle;
    PSG_DI = 8'h00;
    case (state_q)
      StAddr: begin
        bus    = BusAddr;
        PSG_DI = {4'h0, cmd_q.addr};
      end
      StXfer: begin
        if (cmd_q.we) begin
          bus    = BusWrite;
          PSG_DI = cmd_q.data;
        end else begin
          bus = BusRead;
        end
      end
      default: ;
    endcase
  end

  assign {PSG_BDIR, PSG_BC} = bus;
  assign CPU_ACK   = (state_q == StDone) && cmd_cpu_q;
  assign CPU_RDATA = rdata_q;
  assign PL_READY  = !fifo_full;
  assign BUSY      = (state_q != StIdle) || !fifo_empty;

endmodule
